// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline front end: datapath width, the NOP
// used to flush IF/ID, the fetch FSM state type and a word-alignment helper.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Instructions are word aligned; low address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer
// One-word skid register that parks a fetched instruction while the
// pipeline is stalled.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   load     in   capture din, mark valid
//   clear    in   drop contents (redirect)
//   consume  in   word has been delivered, mark empty
//   din      in   word to capture
//   data     out  buffered word
//   valid    out  buffer holds a word
module fetch_hold_buffer
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic            consume,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] data,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clear || consume) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage and writer side of the IF/ID register. Keeps the
// PC, fetches over a req/ready + valid handshake (one request in flight),
// parks words in a hold buffer during stalls and flushes IF/ID with a
// bubble on branch redirect.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   stall                        hazard unit: deliver nothing new
//   redirect, redirectPC         taken branch/jump and its target
//   memReq, memAddr              request to instruction memory
//   memReady                     memory accepts the request this cycle
//   memValid, memData            returned instruction word
//   outPC, outInstruction        IF/ID inPC / inInstruction
//   outWriteEnable               IF/ID single-cycle load pulse
//
// state | meaning
// IDLE  | just out of reset, start fetching on next edge
// REQ   | memReq high at memAddr=pc, waiting for memReady
// WAIT  | request accepted, waiting for memValid
// HOLD  | word parked in hold buffer until stall drops
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPC,
  output logic            memReq,
  output logic [XLEN-1:0] memAddr,
  input  logic            memReady,
  input  logic            memValid,
  input  logic [XLEN-1:0] memData,
  output logic [XLEN-1:0] outPC,
  output logic [XLEN-1:0] outInstruction,
  output logic            outWriteEnable
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            discard;
  logic [XLEN-1:0] hold_data;
  logic            hold_valid;
  logic            buf_load;
  logic            buf_consume;

  assign pc_next = pc + PC_STEP;  // wraps modulo 2^32
  assign target  = align_word(redirectPC);

  assign buf_load    = !redirect && (state == WAIT) && memValid && !discard && stall;
  assign buf_consume = !redirect && (state == HOLD) && !stall && hold_valid;

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (redirect),
    .consume (buf_consume),
    .din     (memData),
    .data    (hold_data),
    .valid   (hold_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      memReq         <= 1'b0;
      memAddr        <= RESET_PC;
      outPC          <= '0;
      outInstruction <= '0;
      outWriteEnable <= 1'b0;
    end else if (redirect) begin
      // Bubble goes out regardless of stall; the old path is abandoned.
      pc             <= target;
      outPC          <= '0;
      outInstruction <= NOP_INSTR;
      outWriteEnable <= 1'b1;
      case (state)
        REQ: begin
          if (memReady) begin
            // Request already accepted: its response must be thrown away.
            state   <= WAIT;
            discard <= 1'b1;
            memReq  <= 1'b0;
          end else begin
            memAddr <= target;
          end
        end
        WAIT: begin
          if (memValid) begin
            discard <= 1'b0;
            state   <= REQ;
            memReq  <= 1'b1;
            memAddr <= target;
          end else begin
            discard <= 1'b1;
          end
        end
        default: begin  // IDLE, HOLD
          state   <= REQ;
          memReq  <= 1'b1;
          memAddr <= target;
        end
      endcase
    end else begin
      outWriteEnable <= 1'b0;
      case (state)
        IDLE: begin
          state   <= REQ;
          memReq  <= 1'b1;
          memAddr <= pc;
        end
        REQ: begin
          if (memReady) begin
            state  <= WAIT;
            memReq <= 1'b0;
          end
        end
        WAIT: begin
          if (memValid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
              memReq  <= 1'b1;
              memAddr <= pc;
            end else if (!stall) begin
              outInstruction <= memData;
              outPC          <= pc_next;
              outWriteEnable <= 1'b1;
              pc             <= pc_next;
              state          <= REQ;
              memReq         <= 1'b1;
              memAddr        <= pc_next;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && hold_valid) begin
            outInstruction <= hold_data;
            outPC          <= pc_next;
            outWriteEnable <= 1'b1;
            pc             <= pc_next;
            state          <= REQ;
            memReq         <= 1'b1;
            memAddr        <= pc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
